// File: rtl/tube_spawner.sv
// tube_spawner: entry-column generator for the scrolling Flappy Bird tube field.
//
// On every qualified scroll tick (shift_tick=1, pause=0) the spawner emits one column into the
// field: either a column of the current tube (TUBE_W columns wide, pattern latched at spawn) or a
// blank gap column. A new tube is spawned once the gap reaches the mode-selected length, or at
// once if the field's top row reports empty.
//
// Optional feature: define RAND_GAP_EN to add an 8-bit LFSR that lengthens each gap by 0..3.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-low reset
//   shift_tick  one-cycle pulse, field shifts this cycle
//   mode        gap select 0/1/2 (3 behaves as 0)
//   pause       freeze spawner, entry column forced blank
//   pattern     tube column pattern (1 = lit pixel), sampled at spawn
//   line_test   top-row occupancy of the field, all-zero = empty
//   light_o     registered entry column
//   spawn_o     one-cycle pulse aligned with the first column of each tube
//   tube_count  tubes spawned since reset, saturating at 255
module tube_spawner #(
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned TUBE_W = 1,
    parameter int unsigned GAP0   = 4,
    parameter int unsigned GAP1   = 7,
    parameter int unsigned GAP2   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_tick,
    input  logic [1:0]        mode,
    input  logic              pause,
    input  logic [HEIGHT-1:0] pattern,
    input  logic [WIDTH-1:0]  line_test,
    output logic [HEIGHT-1:0] light_o,
    output logic              spawn_o,
    output logic [7:0]        tube_count
);

    localparam int unsigned GapMax01 = (GAP0 > GAP1) ? GAP0 : GAP1;
    localparam int unsigned GapMax   = (GapMax01 > GAP2) ? GapMax01 : GAP2;
`ifdef RAND_GAP_EN
    localparam int unsigned GapSat   = GapMax + 3;
`else
    localparam int unsigned GapSat   = GapMax;
`endif
    localparam int unsigned GW       = $clog2(GapMax + 4) + 1;
    localparam int unsigned CW       = $clog2(TUBE_W + 1) + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEmit = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [HEIGHT-1:0] pat_q, pat_d;
    logic [HEIGHT-1:0] light_q, light_d;
    logic              spawn_q, spawn_d;
    logic [7:0]        count_q, count_d;
    logic [GW-1:0]     gap_sel;
    logic [GW-1:0]     gap_eff;
    logic              do_spawn;

`ifdef RAND_GAP_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [1:0] extra_q, extra_d;

    // Fibonacci LFSR, taps 8,6,5,4
    always_comb begin
        lfsr_d = lfsr_q;
        if (shift_tick && !pause) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign gap_eff = gap_sel + GW'(extra_q);
`else
    assign gap_eff = gap_sel;
`endif

    // Resampled every tick so a mode change takes effect on the very next tick.
    always_comb begin
        case (mode)
            2'd1:    gap_sel = GW'(GAP1);
            2'd2:    gap_sel = GW'(GAP2);
            default: gap_sel = GW'(GAP0);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        col_cnt_d = col_cnt_q;
        pat_d     = pat_q;
        light_d   = light_q;
        spawn_d   = 1'b0;
        count_d   = count_q;
        do_spawn  = 1'b0;
`ifdef RAND_GAP_EN
        extra_d   = extra_q;
`endif

        if (pause) begin
            light_d = '0;
        end else if (shift_tick) begin
            case (state_q)
                StIdle: begin
                    do_spawn = 1'b1;
                end
                StEmit: begin
                    light_d   = pat_q;
                    col_cnt_d = col_cnt_q + 1'b1;
                    if (col_cnt_q == CW'(TUBE_W - 1)) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
`ifdef RAND_GAP_EN
                        extra_d   = lfsr_q[1:0];
`endif
                    end
                end
                StGap: begin
                    // gap_cnt counts blank columns already emitted, so G blanks separate tubes
                    if (gap_cnt_q >= gap_eff || line_test == '0) begin
                        do_spawn = 1'b1;
                    end else begin
                        light_d = '0;
                        if (gap_cnt_q < GW'(GapSat)) begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    light_d = '0;
                end
            endcase

            if (do_spawn) begin
                pat_d     = pattern;
                light_d   = pattern;
                spawn_d   = 1'b1;
                col_cnt_d = CW'(1);
                gap_cnt_d = '0;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                if (TUBE_W > 1) begin
                    state_d = StEmit;
                end else begin
                    state_d = StGap;
`ifdef RAND_GAP_EN
                    extra_d = lfsr_q[1:0];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            col_cnt_q <= '0;
            pat_q     <= '0;
            light_q   <= '0;
            spawn_q   <= 1'b0;
            count_q   <= 8'd0;
`ifdef RAND_GAP_EN
            lfsr_q    <= 8'hA5;
            extra_q   <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            col_cnt_q <= col_cnt_d;
            pat_q     <= pat_d;
            light_q   <= light_d;
            spawn_q   <= spawn_d;
            count_q   <= count_d;
`ifdef RAND_GAP_EN
            lfsr_q    <= lfsr_d;
            extra_q   <= extra_d;
`endif
        end
    end

    assign light_o    = light_q;
    assign spawn_o    = spawn_q;
    assign tube_count = count_q;

endmodule

// File: tb/tb_tube_spawner.sv
// Bench for tube_spawner: two instances (TUBE_W=1 and TUBE_W=3) share stimulus. A behavioural
// model predicts each cycle's outputs into a scoreboard queue; directed checks cover spawn
// spacing, pause, mode change, pattern latching, saturation and reset mid-tube.
module tb_tube_spawner;

    logic        clk;
    logic        reset;
    logic        shift_tick;
    logic [1:0]  mode;
    logic        pause;
    logic [15:0] pattern;
    logic [15:0] line_test;
    logic [15:0] light1, light3;
    logic        spawn1, spawn3;
    logic [7:0]  cnt1, cnt3;

    int n_cmp = 0;
    int n_err = 0;

    tube_spawner #(.TUBE_W(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .shift_tick (shift_tick),
        .mode       (mode),
        .pause      (pause),
        .pattern    (pattern),
        .line_test  (line_test),
        .light_o    (light1),
        .spawn_o    (spawn1),
        .tube_count (cnt1)
    );

    tube_spawner #(.TUBE_W(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .shift_tick (shift_tick),
        .mode       (mode),
        .pause      (pause),
        .pattern    (pattern),
        .line_test  (line_test),
        .light_o    (light3),
        .spawn_o    (spawn3),
        .tube_count (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l1;
        logic        s1;
        logic [7:0]  c1;
        logic [15:0] l3;
        logic        s3;
        logic [7:0]  c3;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state, index 0 -> TUBE_W=1, index 1 -> TUBE_W=3
    logic [15:0] m_light [2];
    logic [15:0] m_pat   [2];
    bit          m_spawn [2];
    int          m_cnt   [2];
    bit          m_started [2];
    int          m_left  [2];
    int          m_blank [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int gap_of(input logic [1:0] md);
        case (md)
            2'd1:    return 7;
            2'd2:    return 9;
            default: return 4;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic tk, input logic [1:0] md,
                              input logic ps, input logic [15:0] pat, input logic [15:0] lt);
        for (int k = 0; k < 2; k++) begin
            int tw;
            tw = (k == 0) ? 1 : 3;
            m_spawn[k] = 1'b0;
            if (!rst) begin
                m_light[k] = '0;
                m_pat[k] = '0;
                m_cnt[k] = 0;
                m_started[k] = 1'b0;
                m_left[k] = 0;
                m_blank[k] = 0;
            end else if (ps) begin
                m_light[k] = '0;
            end else if (tk) begin
                if (!m_started[k] || (m_left[k] == 0 && (m_blank[k] >= gap_of(md) || lt == 0))) begin
                    m_started[k] = 1'b1;
                    m_pat[k] = pat;
                    m_light[k] = pat;
                    m_spawn[k] = 1'b1;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                    m_left[k] = tw - 1;
                    m_blank[k] = 0;
                end else if (m_left[k] > 0) begin
                    m_light[k] = m_pat[k];
                    m_left[k]--;
                end else begin
                    m_light[k] = '0;
                    if (m_blank[k] < 9) m_blank[k]++;
                end
            end
        end
    endtask

    // One clock: drive inputs, predict, then compare just after the edge.
    task automatic cycle(input logic rst, input logic tk, input logic [1:0] md, input logic ps,
                         input logic [15:0] pat, input logic [15:0] lt);
        exp_t e;
        reset = rst;
        shift_tick = tk;
        mode = md;
        pause = ps;
        pattern = pat;
        line_test = lt;
        model_step(rst, tk, md, ps, pat, lt);
        e.l1 = m_light[0];
        e.s1 = m_spawn[0];
        e.c1 = 8'(m_cnt[0]);
        e.l3 = m_light[1];
        e.s3 = m_spawn[1];
        e.c3 = 8'(m_cnt[1]);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_light1", 32'(light1), 32'(e.l1));
        check("sb_spawn1", 32'(spawn1), 32'(e.s1));
        check("sb_count1", 32'(cnt1), 32'(e.c1));
        check("sb_light3", 32'(light3), 32'(e.l3));
        check("sb_spawn3", 32'(spawn3), 32'(e.s3));
        check("sb_count3", 32'(cnt3), 32'(e.c3));
    endtask

    // Ticks from just after a spawn until dut1's next spawn; -1 if none within the bound.
    task automatic run_period(input logic [1:0] md, output int period);
        period = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, md, 1'b0, 16'h0183, 16'h0001);
            if (spawn1) begin
                period = i + 1;
                break;
            end
        end
    endtask

    initial begin
        int p;

        // Reset, then idle cycles without ticks
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 16'h0183, 16'h0000);
        check("rst_light", 32'(light1), 32'h0);
        check("rst_spawn", 32'(spawn1), 32'h0);
        check("rst_count", 32'(cnt1), 32'h0);

        // First tick spawns from idle
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h0183, 16'h0000);
        check("first_light", 32'(light1), 32'h0183);
        check("first_spawn", 32'(spawn1), 32'h1);
        check("first_count", 32'(cnt1), 32'h1);

        // G blank columns between tubes, so the next spawn is G+1 ticks later
        run_period(2'd0, p);
        check("period_m0", 32'(p), 32'd5);
        run_period(2'd1, p);
        check("period_m1", 32'(p), 32'd8);
        run_period(2'd2, p);
        check("period_m2", 32'(p), 32'd10);
        run_period(2'd3, p);
        check("period_m3", 32'(p), 32'd5);

        // Pause mid-gap: two blanks done, five paused ticks, three more ticks to spawn
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h0183, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h0183, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 1'b1, 16'h0183, 16'h0001);
            check("pause_light", 32'(light1), 32'h0);
        end
        run_period(2'd0, p);
        check("pause_resume", 32'(p), 32'd3);

        // Mode drop mid-gap with gap already past the new length spawns on the next tick
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 2'd2, 1'b0, 16'h0183, 16'h0001);
        check("mode_wait", 32'(spawn1), 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h0183, 16'h0001);
        check("mode_drop", 32'(spawn1), 32'h1);

        // Wide tube holds the latched pattern for three columns
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hF00F, 16'h0001);
        check("w3_col1", 32'(light3), 32'hF00F);
        check("w3_spawn", 32'(spawn3), 32'h1);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h1234, 16'h0001);
        check("w3_col2", 32'(light3), 32'hF00F);
        check("w3_nospawn", 32'(spawn3), 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h1234, 16'h0001);
        check("w3_col3", 32'(light3), 32'hF00F);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h1234, 16'h0001);
        check("w3_gap", 32'(light3), 32'h0);

        // Pause during emission suspends the column count
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h0C30, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hFFFF, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b1, 16'hFFFF, 16'h0001);
        check("wp_paused", 32'(light3), 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 1'b1, 16'hFFFF, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hFFFF, 16'h0001);
        check("wp_col3", 32'(light3), 32'h0C30);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hFFFF, 16'h0001);
        check("wp_gap", 32'(light3), 32'h0);

        // Empty field spawns every tick; count saturates
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'(i), 16'h0000);
        end
        check("sat_count", 32'(cnt1), 32'd255);

        // Reset mid-emission aborts the tube
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hAAAA, 16'h0001);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'hAAAA, 16'h0001);
        check("mid_emit", 32'(light3), 32'hAAAA);
        cycle(1'b0, 1'b1, 2'd0, 1'b0, 16'hAAAA, 16'h0001);
        check("abort_light", 32'(light3), 32'h0);
        check("abort_count", 32'(cnt3), 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 16'h00FF, 16'h0001);
        check("respawn_light", 32'(light3), 32'h00FF);
        check("respawn_count", 32'(cnt3), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
